// File: rtl/multicyc_exec.sv
// Multicycle execute responder: fixed-latency multiply/MAC and radix-2 restoring divide, result on HI/LO.
// Optional: define MULTICYC_DIV_FAST_ZERO_EN to answer divide-by-zero two cycles after acceptance.
package multicyc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MUL   = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_DIV   = 4'd8,
    OP_DIVU  = 4'd9,
    OP_ADD   = 4'd10
  } oper_t;

  typedef struct packed {
    oper_t       op;
    logic        is_multicyc;
    logic [63:0] hilo;
    logic [31:0] reg0;
    logic [31:0] reg1;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [63:0] hilo;
  } multicyc_resp_t;

endpackage

module multicyc_exec
  import multicyc_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 34
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  multicyc_req_t  req,
  output multicyc_resp_t resp
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] MUL     = 3'd1;
  localparam logic [2:0] DIV_RUN = 3'd2;
  localparam logic [2:0] DIV_FIX = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  // Setup and sign-fix cycles bracket the quotient iterations.
  localparam int         DIV_ITERS = DIV_CYCLES - 2;
  localparam logic [5:0] DIV_LAST  = 6'(DIV_ITERS - 1);
  localparam logic [5:0] MUL_LAST  = 6'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

  function automatic logic is_mul_op(input oper_t op);
    return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(input oper_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] mul_result(input oper_t       op,
                                             input logic [63:0] acc,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic        sgn;
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] prod;
    sgn  = op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB};
    ax   = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    bx   = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    prod = ax * bx;
    case (op)
      OP_MADD, OP_MADDU: return acc + prod;
      OP_MSUB, OP_MSUBU: return acc - prod;
      default:           return prod;
    endcase
  endfunction

  logic [2:0]  state_q;
  logic [5:0]  cnt_q;
  oper_t       op_q;
  logic [31:0] reg0_q;
  logic [31:0] reg1_q;
  logic [63:0] hilo_in_q;
  logic [63:0] hilo_q;
  logic [31:0] div_rem_q;
  logic [31:0] div_quo_q;
  logic [31:0] div_dvsr_q;
  logic        div_qneg_q;
  logic        div_rneg_q;
  logic        div_zero_q;

  logic        accept;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [31:0] div_rem_nxt;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    accept      = 1'b0;
    div_shift   = {div_rem_q, div_quo_q[31]};
    div_diff    = div_shift[31:0] - div_dvsr_q;
    div_ge      = (div_shift >= {1'b0, div_dvsr_q});
    div_rem_nxt = div_ge ? div_diff : div_shift[31:0];
    quo_fix     = div_qneg_q ? (~div_quo_q + 32'd1) : div_quo_q;
    rem_fix     = div_rneg_q ? (~div_rem_q + 32'd1) : div_rem_q;
    if ((state_q == IDLE) && req.is_multicyc && (is_mul_op(req.op) || is_div_op(req.op)))
      accept = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NOP;
      reg0_q     <= '0;
      reg1_q     <= '0;
      hilo_in_q  <= '0;
      hilo_q     <= '0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_dvsr_q <= '0;
      div_qneg_q <= 1'b0;
      div_rneg_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= req.op;
            reg0_q    <= req.reg0;
            reg1_q    <= req.reg1;
            hilo_in_q <= req.hilo;
            cnt_q     <= '0;
            if (is_mul_op(req.op)) begin
              if (MUL_CYCLES == 1) begin
                hilo_q  <= mul_result(req.op, req.hilo, req.reg0, req.reg1);
                state_q <= DONE;
              end else begin
                state_q <= MUL;
              end
            end else begin
              div_rem_q  <= '0;
              div_quo_q  <= mag32(req.reg0, req.op == OP_DIV);
              div_dvsr_q <= mag32(req.reg1, req.op == OP_DIV);
              div_qneg_q <= (req.op == OP_DIV) && (req.reg0[31] ^ req.reg1[31]);
              div_rneg_q <= (req.op == OP_DIV) && req.reg0[31];
              div_zero_q <= (req.reg1 == 32'h0);
`ifdef MULTICYC_DIV_FAST_ZERO_EN
              state_q    <= (req.reg1 == 32'h0) ? DIV_FIX : DIV_RUN;
`else
              state_q    <= DIV_RUN;
`endif
            end
          end
        end
        MUL: begin
          if (cnt_q == MUL_LAST) begin
            hilo_q  <= mul_result(op_q, hilo_in_q, reg0_q, reg1_q);
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DIV_RUN: begin
          div_rem_q <= div_rem_nxt;
          div_quo_q <= {div_quo_q[30:0], div_ge};
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            state_q <= DIV_FIX;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DIV_FIX: begin
          // A zero divisor returns the raw dividend in HI regardless of sign handling.
          hilo_q  <= div_zero_q ? {reg0_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    resp       = '0;
    resp.valid = (state_q == DONE) && !flush;
    resp.ready = (state_q == DONE) && !flush;
    resp.hilo  = hilo_q;
  end

endmodule

// File: tb/tb_multicyc_exec.sv
// Directed scoreboard bench for multicyc_exec; honours MULTICYC_DIV_FAST_ZERO_EN for divide-by-zero latency.
module tb_multicyc_exec;
  import multicyc_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;
`ifdef MULTICYC_DIV_FAST_ZERO_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 34;
`endif

  typedef struct {
    string       tag;
    logic [63:0] hilo;
    int          lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  multicyc_req_t  req;
  multicyc_resp_t resp;

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          t_acc      = 0;
  logic [63:0] last_exp   = 64'h0;
  exp_t        sb[$];

  multicyc_exec #(.MUL_CYCLES(MUL_LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .req  (req),
    .resp (resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input oper_t op, input logic [63:0] hilo, input logic [31:0] r0,
                       input logic [31:0] r1, input int delay);
    req.op          = op;
    req.is_multicyc = 1'b1;
    req.hilo        = hilo;
    req.reg0        = r0;
    req.reg1        = r1;
    t_acc           = cyc + delay;
  endtask

  task automatic expect_resp(input string tag, input logic [63:0] hilo, input int lat);
    exp_t e;
    e.tag  = tag;
    e.hilo = hilo;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic idle_req();
    req.is_multicyc = 1'b0;
    req.op          = OP_NOP;
  endtask

  task automatic wait_resp();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (resp.valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        check({e.tag, "_hilo"}, resp.hilo, e.hilo);
        check({e.tag, "_lat"}, 64'(cyc - t_acc), 64'(e.lat));
        check({e.tag, "_ready"}, 64'(resp.ready), 64'(1));
        last_exp = e.hilo;
      end
    end
    if (!seen) begin
      e = sb.pop_front();
      check({e.tag, "_timeout"}, 64'(resp.valid), 64'(1));
    end
  endtask

  task automatic run(input string tag, input oper_t op, input logic [63:0] hilo,
                     input logic [31:0] r0, input logic [31:0] r1,
                     input logic [63:0] exp, input int lat);
    issue(op, hilo, r0, r1, 0);
    expect_resp(tag, exp, lat);
    wait_resp();
    idle_req();
    @(negedge clk);
    check({tag, "_once"}, 64'(resp.valid), 64'(0));
  endtask

  task automatic no_resp(input string tag, input int n);
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (resp.valid) nvalid++;
    end
    check(tag, 64'(nvalid), 64'(0));
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(resp.valid), 64'(0));
    check("rst_ready", 64'(resp.ready), 64'(0));
    check("rst_hilo", resp.hilo, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Multiply class
    run("mult",  OP_MULT,  64'h0, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
    run("multu", OP_MULTU, 64'h0, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, MUL_LAT);
    run("madd",  OP_MADD,  64'h10, 32'h3, 32'hFFFF_FFFF, 64'h0000_0000_0000_000D, MUL_LAT);
    run("msubu", OP_MSUBU, 64'h0, 32'h1, 32'h1, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
    run("mul",   OP_MUL,   64'h1234, 32'h7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    run("maddu", OP_MADDU, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1, 32'h1, 64'h0, MUL_LAT);
    run("msub",  OP_MSUB,  64'h0, 32'hFFFF_FFFE, 32'h3, 64'h6, MUL_LAT);

    // Divide class
    run("div_neg",  OP_DIV,  64'h0, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
    run("div_ovf",  OP_DIV,  64'h0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_LAT);
    run("divu",     OP_DIVU, 64'h0, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT);
    run("divu_dz",  OP_DIVU, 64'h0, 32'h1234_5678, 32'h0, 64'h1234_5678_FFFF_FFFF, DZ_LAT);
    run("div_dz",   OP_DIV,  64'h0, 32'hFFFF_FFF9, 32'h0, 64'hFFFF_FFF9_FFFF_FFFF, DZ_LAT);

    // Ineligible requests never answer
    issue(OP_ADD, 64'h0, 32'h1, 32'h1, 0);
    no_resp("unsupported_op", 10);
    issue(OP_MULT, 64'h0, 32'h1, 32'h1, 0);
    req.is_multicyc = 1'b0;
    no_resp("not_multicyc", 10);
    idle_req();
    check("ineligible_hilo", resp.hilo, last_exp);

    // Flush together with an eligible request in IDLE
    issue(OP_MULTU, 64'h0, 32'h2, 32'h2, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle_req();
    no_resp("flush_idle", 8);
    check("flush_idle_hilo", resp.hilo, last_exp);

    // Flush in the DONE cycle suppresses valid
    issue(OP_MULT, 64'h0, 32'h3, 32'h3, 0);
    repeat (MUL_LAT) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done_valid", 64'(resp.valid), 64'(0));
    check("flush_done_ready", 64'(resp.ready), 64'(0));
    @(negedge clk);
    flush = 1'b0;
    idle_req();
    no_resp("flush_done_after", 5);

    // Back-to-back: second request appears in the DONE cycle of the first
    issue(OP_MULT, 64'h0, 32'h3, 32'h4, 0);
    expect_resp("b2b_mult", 64'hC, MUL_LAT);
    wait_resp();
    issue(OP_DIVU, 64'h0, 32'd50, 32'd5, 1);
    expect_resp("b2b_divu", {32'd0, 32'd10}, DIV_LAT);
    wait_resp();
    idle_req();
    @(negedge clk);
    check("b2b_once", 64'(resp.valid), 64'(0));

    // Flush mid-divide: no response, result register untouched
    issue(OP_DIVU, 64'h0, 32'd1000, 32'd3, 0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    idle_req();
    @(negedge clk);
    flush = 1'b0;
    no_resp("flush_div", 40);
    check("flush_div_hilo", resp.hilo, last_exp);
    run("after_flush", OP_MULTU, 64'h0, 32'd5, 32'd6, 64'h1E, MUL_LAT);

    // Reset mid-divide
    issue(OP_DIV, 64'h0, 32'd100, 32'd7, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    idle_req();
    #1;
    check("rst_mid_valid", 64'(resp.valid), 64'(0));
    check("rst_mid_hilo", resp.hilo, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    no_resp("post_rst", 40);
    run("recover", OP_MULT, 64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, MUL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
